iterative_shifter: RTL and testbench

- Multi-cycle, parametrised shifter; successor to the fixed two-bit shift stage.
- Shifts a WIDTH-bit operand by a run-time amount, STEP bit positions per clock, until the requested amount is reached.
- Modes: logical left, logical right, arithmetic right, rotate right.
- Start/busy/done handshake; used by the ALU when a full single-cycle barrel shifter is too costly.

---
 rtl/iterative_shifter.sv | 104 ++++++++++
 tb/tb_iterative_shifter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iterative_shifter : multi-cycle SLL/SRL/SRA/ROR shifter, STEP bits per clock
// Revision 1.0
// ---------------------------------------------------------------------------
module iterative_shifter #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 2,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SW-1:0]    shamt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]    MODE_SLL = 2'b00;
    localparam logic [1:0]    MODE_SRL = 2'b01;
    localparam logic [1:0]    MODE_SRA = 2'b10;
    localparam logic [SW-1:0] STEP_W   = SW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SW-1:0]      rem;
    logic [1:0]         mode_q;
    logic               accept;
    logic [SW-1:0]      step;
    logic [SW-1:0]      rem_next;
    logic [WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0] rot_pair;

    // Per-cycle shift by min(STEP, rem) in the latched mode
    always_comb begin
        step     = (rem < STEP_W) ? rem : STEP_W;
        rem_next = rem - step;
        rot_pair = {result, result} >> step;
        case (mode_q)
            MODE_SLL: shifted = result << step;
            MODE_SRL: shifted = result >> step;
            MODE_SRA: shifted = WIDTH'($signed(result) >>> step);
            default:  shifted = rot_pair[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done       = (state == DONE);
                accept     = start;
                state_next = IDLE;
                if (start) begin
                    state_next = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (rem_next == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result <= '0;
            rem    <= '0;
            mode_q <= MODE_SLL;
        end else if (accept) begin
            result <= A;
            rem    <= shamt;
            mode_q <= mode;
        end else if (state == SHIFT) begin
            result <= shifted;
            rem    <= rem_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterative_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iterative_shifter : directed + random checks against a whole-shift model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_iterative_shifter;

    localparam int WIDTH = 32;
    localparam int STEP  = 2;
    localparam int SW    = $clog2(WIDTH);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A     = '0;
    logic [SW-1:0]    shamt = '0;
    logic [1:0]       mode  = '0;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .shamt  (shamt),
        .mode   (mode),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    // Whole shift in one go; the DUT must reach the same value step by step
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                   input int sh, input logic [1:0] md);
        logic [WIDTH-1:0] r;
        case (md)
            2'b00:   r = a << sh;
            2'b01:   r = a >> sh;
            2'b10:   r = WIDTH'($signed(a) >>> sh);
            default: r = (sh == 0) ? a : ((a >> sh) | (a << (WIDTH - sh)));
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input int sh);
        return (sh + STEP - 1) / STEP + 1;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive an operation; returns at #1 after the accepting edge (cycle N+1)
    task automatic issue(input logic [WIDTH-1:0] a, input int sh, input logic [1:0] md);
        A     = a;
        shamt = SW'(sh);
        mode  = md;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        A     = 'x;
    endtask

    // Called at cycle first_cyc after acceptance; returns in the done cycle
    task automatic wait_done(input string tag, input int first_cyc,
                             input logic [WIDTH-1:0] exp_res, input int exp_lat);
        int cyc  = first_cyc;
        int bcnt = 0;
        int both = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clock);
            #1;
            cyc++;
        end
        if (busy === 1'b1 && done === 1'b1) both++;
        check({tag, "_done"},    32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busycnt"}, 32'(bcnt), 32'(exp_lat - first_cyc));
        check({tag, "_overlap"}, 32'(both), 32'd0);
        check({tag, "_result"},  result, exp_res);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        int               rs;
        logic [1:0]       rm;
        int               seen;

        repeat (3) @(posedge clock);
        #1;
        check("rst_result", result, '0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // SRA sign fill, odd final step
        issue(32'h8000_0000, 5, 2'b10);
        wait_done("sra5", 1, 32'hFC00_0000, 4);
        @(posedge clock);
        #1;
        check("sra5_done_pulse", 32'(done), 32'd0);
        check("sra5_hold", result, 32'hFC00_0000);

        // SLL by 31
        issue(32'h0000_0001, 31, 2'b00);
        wait_done("sll31", 1, 32'h8000_0000, 17);

        // SRL then ROR started in the DONE cycle
        @(posedge clock);
        #1;
        issue(32'hF000_0000, 4, 2'b01);
        wait_done("srl4", 1, 32'h0F00_0000, 3);
        issue(32'h0000_0001, 1, 2'b11);
        wait_done("ror1_b2b", 1, 32'h8000_0000, 2);

        // shamt = 0
        @(posedge clock);
        #1;
        issue(32'h1234_5678, 0, 2'b10);
        wait_done("zero", 1, 32'h1234_5678, 1);

        // start during SHIFT is ignored
        @(posedge clock);
        #1;
        issue(32'h0000_0003, 9, 2'b00);
        A     = 32'hFFFF_FFFF;
        shamt = SW'(1);
        mode  = 2'b11;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("ignore", 2, 32'h0000_0600, 6);

        // Reset in the 2nd SHIFT cycle abandons the operation
        @(posedge clock);
        #1;
        issue(32'hDEAD_BEEF, 20, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_result", result, '0);
        check("midrst_busy",   32'(busy), 32'd0);
        check("midrst_done",   32'(done), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        issue(32'h0000_0100, 8, 2'b01);
        wait_done("after_rst", 1, 32'h0000_0001, 5);

        // Random operations, occasionally back-to-back from DONE
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = $urandom_range(0, WIDTH - 1);
            rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clock);
                #1;
            end
            issue(ra, rs, rm);
            wait_done($sformatf("rnd%0d_m%0d_s%0d", i, rm, rs), 1, ref_shift(ra, rs, rm), ref_lat(rs));
        end

        @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
